unary_decoder: RTL

UNARY_DECODER -- requirements
Module: unary_decoder

---
 rtl/unary_decoder.sv | 89 ++++++++
 1 files changed

// File: rtl/unary_decoder.sv
// Counts a unary pulse stream into a binary product; a run of GAP zeros ends the stream.
// Latency: out_valid rises the cycle after the GAP-th trailing zero sample.
// Backpressure: result held in DONE until out_rdy; the stream input is ignored meanwhile.
module unary_decoder #(
  parameter int WIDTH     = 4,
  parameter int OUT_WIDTH = 2*WIDTH,
  parameter int GAP       = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_rdy,
  input  logic                 in,
  input  logic                 out_rdy,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] product,
  output logic                 ovf,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ARMED, COUNT, DONE} state_t;

  localparam logic [3:0]           ZRUN_LAST = 4'(GAP - 1);
  localparam logic [OUT_WIDTH-1:0] COUNT_MAX = '1;

  state_t               state, state_nxt;
  logic [OUT_WIDTH-1:0] count, count_nxt;
  logic [3:0]           zrun, zrun_nxt;
  logic                 ovf_q, ovf_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      zrun  <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      zrun  <= zrun_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    zrun_nxt  = zrun;
    ovf_nxt   = ovf_q;
    case (state)
      IDLE: begin
        if (in_rdy) begin
          state_nxt = ARMED;
          count_nxt = '0;
          zrun_nxt  = '0;
          ovf_nxt   = 1'b0;
        end
      end
      ARMED, COUNT: begin
        if (in) begin
          state_nxt = COUNT;
          zrun_nxt  = '0;
          if (state == ARMED)
            count_nxt = OUT_WIDTH'(1);
          else if (count == COUNT_MAX)
            ovf_nxt = 1'b1;
          else
            count_nxt = count + 1'b1;
        end else if (zrun == ZRUN_LAST) begin
          // GAP-th consecutive zero closes the stream; a shorter run is a row gap
          state_nxt = DONE;
          zrun_nxt  = '0;
        end else begin
          zrun_nxt = zrun + 4'd1;
        end
      end
      DONE: begin
        if (out_rdy)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == DONE);
  assign busy      = (state == ARMED) || (state == COUNT);
  assign product   = count;
  assign ovf       = ovf_q;

endmodule
